// File: rtl/spi_slave_pkg.sv
// spi_slave_pkg -- shared types and defaults for the SPI mode-0 slave.
//   state_t                : FSM encoding (IDLE, SHIFT)
//   SPI_DEFAULT_DATA_WIDTH : default frame length in bits
//   SPI_DEFAULT_FIFO_DEPTH : default RX FIFO entries (SPI_SLAVE_RX_FIFO_EN builds)
//   spi_cnt_width()        : bit-counter width for a given frame length
package spi_slave_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam int unsigned SPI_DEFAULT_DATA_WIDTH = 8;
    localparam int unsigned SPI_DEFAULT_FIFO_DEPTH = 4;

    // Width of a counter holding 0..width-1; never narrower than one bit.
    function automatic int unsigned spi_cnt_width(input int unsigned width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/spi_slave_rx_fifo.sv
// spi_slave_rx_fifo -- first-word fall-through receive FIFO for spi_slave.
// Only instantiated when SPI_SLAVE_RX_FIFO_EN is defined.
// Ports:
//   clk_i, rst_i       : clock, asynchronous active-high reset
//   push_i/push_data_i : write request and data; accepted when not full,
//                        or when full and popped in the same cycle
//   pop_i              : consumer takes the head entry
//   data_o / valid_o   : head entry (0 when empty) / FIFO not empty
//   full_o             : all DEPTH entries occupied
module spi_slave_rx_fifo #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  push_i,
    input  logic [DATA_WIDTH-1:0] push_data_i,
    input  logic                  pop_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  valid_o,
    output logic                  full_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    // Pointers carry one extra wrap bit to tell full from empty.
    logic [AW:0]           wr_ptr_q, wr_ptr_d;
    logic [AW:0]           rd_ptr_q, rd_ptr_d;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic                  empty;
    logic                  do_wr;
    logic                  do_rd;

    assign empty  = (wr_ptr_q == rd_ptr_q);
    assign full_o = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    // A pop frees the head slot in the same cycle, so a push on full is
    // still accepted when it coincides with a pop.
    assign do_rd = pop_i && !empty;
    assign do_wr = push_i && (!full_o || do_rd);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_wr) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_rd) rd_ptr_d = rd_ptr_q + 1'b1;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            if (do_wr) mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
        end
    end

    assign valid_o = !empty;
    assign data_o  = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/spi_slave.sv
// spi_slave -- SPI mode 0 (CPOL=0, CPHA=0) slave, MSB first, oversampled
// in the clk domain (sclk must be no faster than clk/8).
// Optional feature: define SPI_SLAVE_RX_FIFO_EN to buffer received frames in
// a FIFO_DEPTH-entry FIFO; otherwise a single holding register is used.
// Ports:
//   clk, reset            : system clock, asynchronous active-high reset
//   sclk, ss, mosi        : SPI master signals (asynchronous, synchronized here)
//   miso, misoEnable      : serial data out; enable high while selected
//   txData/txValid/txReady: next frame to send; txReady pulses on consumption
//   rxData/rxValid/rxReady: received frame at buffer head; pop on valid&ready
//   txUnderrun            : pulse when a frame loads with txValid low (sends 1s)
//   rxOverrun             : pulse when a completed frame is dropped (buffer full)
//   busy                  : FSM in SHIFT
module spi_slave
    import spi_slave_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = SPI_DEFAULT_DATA_WIDTH,
    parameter int unsigned FIFO_DEPTH = SPI_DEFAULT_FIFO_DEPTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  sclk,
    input  logic                  ss,
    input  logic                  mosi,
    output logic                  miso,
    output logic                  misoEnable,
    input  logic [DATA_WIDTH-1:0] txData,
    input  logic                  txValid,
    output logic                  txReady,
    output logic [DATA_WIDTH-1:0] rxData,
    output logic                  rxValid,
    input  logic                  rxReady,
    output logic                  txUnderrun,
    output logic                  rxOverrun,
    output logic                  busy
);

    localparam int unsigned        CNT_W    = spi_cnt_width(DATA_WIDTH);
    localparam logic [CNT_W-1:0]   LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    // ------------------------------------------------------------------
    // Input synchronizers; the third sclk/ss stage is only for edge detect.
    // ------------------------------------------------------------------
    logic       sclk_s1_q, sclk_s2_q, sclk_s3_q;
    logic       ss_s1_q, ss_s2_q, ss_s3_q;
    logic       mosi_s1_q, mosi_s2_q;
    logic [1:0] settle_q;
    logic       armed_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sclk_s1_q <= 1'b0;
            sclk_s2_q <= 1'b0;
            sclk_s3_q <= 1'b0;
            ss_s1_q   <= 1'b1;
            ss_s2_q   <= 1'b1;
            ss_s3_q   <= 1'b1;
            mosi_s1_q <= 1'b0;
            mosi_s2_q <= 1'b0;
            settle_q  <= '0;
            armed_q   <= 1'b0;
        end else begin
            sclk_s1_q <= sclk;
            sclk_s2_q <= sclk_s1_q;
            sclk_s3_q <= sclk_s2_q;
            ss_s1_q   <= ss;
            ss_s2_q   <= ss_s1_q;
            ss_s3_q   <= ss_s2_q;
            mosi_s1_q <= mosi;
            mosi_s2_q <= mosi_s1_q;
            settle_q  <= {settle_q[0], 1'b1};
            // The ss flops reset high, which would fake a falling edge if ss
            // is already low at reset release. Accept a fall only after a
            // real high level has been seen through the synchronizer.
            if (settle_q[1] && ss_s2_q) armed_q <= 1'b1;
        end
    end

    logic sclk_rise, sclk_fall, ss_fall;

    assign sclk_rise = sclk_s2_q && !sclk_s3_q;
    assign sclk_fall = !sclk_s2_q && sclk_s3_q;
    assign ss_fall   = armed_q && !ss_s2_q && ss_s3_q;

    // ------------------------------------------------------------------
    // Frame FSM and shift registers
    // ------------------------------------------------------------------
    state_t                state_q, state_d;
    logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0] tx_shift_q, tx_shift_d;
    logic [DATA_WIDTH-1:0] rx_shift_q, rx_shift_d;
    logic                  reload_q, reload_d;
    logic                  push_q, push_d;
    logic                  tx_load;

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        tx_shift_d = tx_shift_q;
        rx_shift_d = rx_shift_q;
        reload_d   = reload_q;
        push_d     = 1'b0;
        tx_load    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (ss_fall) begin
                    state_d   = SHIFT;
                    tx_load   = 1'b1;
                    bit_cnt_d = '0;
                    reload_d  = 1'b0;
                end
            end
            SHIFT: begin
                if (ss_s2_q) begin
                    // Deselect abandons any partial frame.
                    state_d    = IDLE;
                    bit_cnt_d  = '0;
                    reload_d   = 1'b0;
                    tx_shift_d = '1;
                end else begin
                    if (sclk_rise) begin
                        rx_shift_d = {rx_shift_q[DATA_WIDTH-2:0], mosi_s2_q};
                        if (bit_cnt_q == LAST_BIT) begin
                            bit_cnt_d = '0;
                            push_d    = 1'b1;
                            reload_d  = 1'b1;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 1'b1;
                        end
                    end
                    // The falling edge after the last bit loads the next
                    // frame instead of shifting, so ss can stay low across
                    // back-to-back frames.
                    if (sclk_fall) begin
                        if (reload_q) begin
                            tx_load  = 1'b1;
                            reload_d = 1'b0;
                        end else begin
                            tx_shift_d = {tx_shift_q[DATA_WIDTH-2:0], 1'b1};
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (tx_load) tx_shift_d = txValid ? txData : '1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            tx_shift_q <= '1;
            rx_shift_q <= '0;
            reload_q   <= 1'b0;
            push_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            tx_shift_q <= tx_shift_d;
            rx_shift_q <= rx_shift_d;
            reload_q   <= reload_d;
            push_q     <= push_d;
        end
    end

    assign txReady    = tx_load && txValid;
    assign txUnderrun = tx_load && !txValid;
    assign miso       = tx_shift_q[DATA_WIDTH-1];
    assign misoEnable = !ss_s2_q;
    assign busy       = (state_q == SHIFT);

    // ------------------------------------------------------------------
    // Receive buffer: push_q is high the cycle after the final rising edge,
    // when rx_shift_q holds the complete frame.
    // ------------------------------------------------------------------
    logic rx_pop;
    logic buf_full;

    assign rx_pop    = rxValid && rxReady;
    assign rxOverrun = push_q && buf_full && !rx_pop;

`ifdef SPI_SLAVE_RX_FIFO_EN
    spi_slave_rx_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (FIFO_DEPTH)
    ) u_rx_fifo (
        .clk_i       (clk),
        .rst_i       (reset),
        .push_i      (push_q),
        .push_data_i (rx_shift_q),
        .pop_i       (rx_pop),
        .data_o      (rxData),
        .valid_o     (rxValid),
        .full_o      (buf_full)
    );
`else
    logic [DATA_WIDTH-1:0] hold_q, hold_d;
    logic                  hold_valid_q, hold_valid_d;

    assign buf_full = hold_valid_q;

    always_comb begin
        hold_d       = hold_q;
        hold_valid_d = hold_valid_q;
        if (rx_pop) hold_valid_d = 1'b0;
        if (push_q && (!hold_valid_q || rx_pop)) begin
            hold_d       = rx_shift_q;
            hold_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_q       <= '0;
            hold_valid_q <= 1'b0;
        end else begin
            hold_q       <= hold_d;
            hold_valid_q <= hold_valid_d;
        end
    end

    assign rxData  = hold_q;
    assign rxValid = hold_valid_q;
`endif

endmodule

// File: tb/tb_spi_slave.sv
// tb_spi_slave -- scoreboard bench for spi_slave (SPI mode 0, 8-bit frames).
// Expected received frames are queued by the stimulus; an independent monitor
// pops and compares whenever the DUT offers rxData (rxValid & rxReady) and
// counts txReady/txUnderrun/rxOverrun pulse cycles. MISO is captured by the
// master model at each sclk rising edge and compared per frame.
module tb_spi_slave;

    localparam int W = 8;
`ifdef SPI_SLAVE_RX_FIFO_EN
    localparam int BUF_DEPTH = 4;
`else
    localparam int BUF_DEPTH = 1;
`endif

    logic         clk = 1'b0;
    logic         reset;
    logic         sclk;
    logic         ss;
    logic         mosi;
    logic         miso;
    logic         misoEnable;
    logic [W-1:0] txData;
    logic         txValid;
    logic         txReady;
    logic [W-1:0] rxData;
    logic         rxValid;
    logic         rxReady;
    logic         txUnderrun;
    logic         rxOverrun;
    logic         busy;

    spi_slave #(
        .DATA_WIDTH (W),
        .FIFO_DEPTH (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .sclk       (sclk),
        .ss         (ss),
        .mosi       (mosi),
        .miso       (miso),
        .misoEnable (misoEnable),
        .txData     (txData),
        .txValid    (txValid),
        .txReady    (txReady),
        .rxData     (rxData),
        .rxValid    (rxValid),
        .rxReady    (rxReady),
        .txUnderrun (txUnderrun),
        .rxOverrun  (rxOverrun),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int n_txready  = 0;
    int n_underrun = 0;
    int n_overrun  = 0;
    logic [W-1:0] exp_rx [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pulse counters and rx scoreboard, sampled mid-cycle.
    always @(negedge clk) begin
        if (!reset) begin
            if (txReady === 1'b1)    n_txready++;
            if (txUnderrun === 1'b1) n_underrun++;
            if (rxOverrun === 1'b1)  n_overrun++;
            if (rxValid === 1'b1 && rxReady === 1'b1) begin
                checks++;
                if (exp_rx.size() == 0) begin
                    failures++;
                    $display("FAIL rx_unexpected: got %02h expected no frame", rxData);
                end else begin
                    logic [W-1:0] e;
                    e = exp_rx.pop_front();
                    if (rxData !== e) begin
                        failures++;
                        $display("FAIL rx_data: got %02h expected %02h", rxData, e);
                    end
                end
            end
        end
    end

    // Master: nbytes frames back-to-back under one ss assertion. Bytes are
    // packed MSB-first in mo/miso_exp; tx_next[23-8b -: 8] is presented on
    // txData during byte b for the reload that follows it. ss rises together
    // with the final sclk fall, so no extra reload happens after the last byte.
    task automatic spi_frame(input int nbytes, input logic [23:0] mo,
                             input logic [23:0] tx_next, input logic [23:0] miso_exp);
        logic [7:0] mb;
        logic [7:0] cap;
        ss = 1'b0;
        repeat (8) @(negedge clk);
        for (int b = 0; b < nbytes; b++) begin
            mb = mo[23-8*b -: 8];
            for (int i = 7; i >= 0; i--) begin
                mosi = mb[i];
                repeat (8) @(negedge clk);
                sclk   = 1'b1;
                cap[i] = miso;
                if (b == 0 && i == 7) begin
                    check("busy_in_frame", {31'd0, busy}, 32'd1);
                    check("miso_en_in_frame", {31'd0, misoEnable}, 32'd1);
                end
                if (i == 7 && b + 1 < nbytes) txData = tx_next[23-8*b -: 8];
                repeat (8) @(negedge clk);
                sclk = 1'b0;
                if (b == nbytes - 1 && i == 0) ss = 1'b1;
            end
            check("miso_byte", {24'd0, cap}, {24'd0, miso_exp[23-8*b -: 8]});
        end
        repeat (16) @(negedge clk);
    endtask

    // Master: only nbits of a frame; optionally deselect with the last fall.
    task automatic spi_partial(input int nbits, input logic [7:0] mb, input bit end_ss);
        ss = 1'b0;
        repeat (8) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            mosi = mb[7-i];
            repeat (8) @(negedge clk);
            sclk = 1'b1;
            repeat (8) @(negedge clk);
            sclk = 1'b0;
            if (end_ss && i == nbits - 1) ss = 1'b1;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_miso"},       {31'd0, miso},       32'd1);
        check({tag, "_misoEnable"}, {31'd0, misoEnable}, 32'd0);
        check({tag, "_txReady"},    {31'd0, txReady},    32'd0);
        check({tag, "_txUnderrun"}, {31'd0, txUnderrun}, 32'd0);
        check({tag, "_rxOverrun"},  {31'd0, rxOverrun},  32'd0);
        check({tag, "_rxValid"},    {31'd0, rxValid},    32'd0);
        check({tag, "_rxData"},     {24'd0, rxData},     32'd0);
        check({tag, "_busy"},       {31'd0, busy},       32'd0);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int tr0, ur0, or0;
        reset   = 1'b1;
        sclk    = 1'b0;
        ss      = 1'b1;
        mosi    = 1'b0;
        txData  = '0;
        txValid = 1'b0;
        rxReady = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        reset = 1'b0;
        repeat (8) @(negedge clk);

        // Single frame: send A5, receive 3C.
        txData = 8'hA5; txValid = 1'b1;
        tr0 = n_txready; ur0 = n_underrun;
        exp_rx.push_back(8'h3C);
        spi_frame(1, {8'h3C, 16'h0}, 24'h0, {8'hA5, 16'h0});
        check("a5_txready_pulses", n_txready - tr0, 1);
        check("a5_underrun_pulses", n_underrun - ur0, 0);

        // Underrun: txValid low at selection, MISO sends all ones.
        txValid = 1'b0;
        tr0 = n_txready; ur0 = n_underrun;
        exp_rx.push_back(8'hC7);
        spi_frame(1, {8'hC7, 16'h0}, 24'h0, {8'hFF, 16'h0});
        check("ur_underrun_pulses", n_underrun - ur0, 1);
        check("ur_txready_pulses", n_txready - tr0, 0);

        // Three frames under one ss assertion.
        txValid = 1'b1; txData = 8'h10;
        tr0 = n_txready;
        exp_rx.push_back(8'h01); exp_rx.push_back(8'h02); exp_rx.push_back(8'h03);
        spi_frame(3, 24'h010203, {8'h11, 8'h12, 8'h00}, 24'h101112);
        check("b2b_txready_pulses", n_txready - tr0, 3);

        // Deselect after 5 bits: partial frame discarded.
        spi_partial(5, 8'hB6, 1'b1);
        repeat (12) @(negedge clk);
        check("partial_no_rxvalid", {31'd0, rxValid}, 32'd0);
        txData = 8'h3E;
        exp_rx.push_back(8'h81);
        spi_frame(1, {8'h81, 16'h0}, 24'h0, {8'h3E, 16'h0});

        // Overrun: consumer stalled, one frame more than the buffer holds.
        rxReady = 1'b0;
        or0 = n_overrun;
        for (int k = 0; k <= BUF_DEPTH; k++) begin
            if (k < BUF_DEPTH) exp_rx.push_back(8'(8'h40 + k));
            spi_frame(1, {8'(8'h40 + k), 16'h0}, 24'h0, {8'h3E, 16'h0});
        end
        check("ovr_pulses", n_overrun - or0, 1);
        check("ovr_head_valid", {31'd0, rxValid}, 32'd1);
        check("ovr_head_data", {24'd0, rxData}, 32'h40);
        rxReady = 1'b1;
        repeat (BUF_DEPTH + 4) @(negedge clk);

        // Reset mid-frame, then a clean frame.
        txData = 8'hC3;
        spi_partial(3, 8'hE7, 1'b0);
        reset = 1'b1;
        #1;
        check_reset_outputs("midrst");
        @(negedge clk);
        ss = 1'b1; sclk = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b0;
        repeat (8) @(negedge clk);
        txData = 8'h96;
        exp_rx.push_back(8'h5A);
        spi_frame(1, {8'h5A, 16'h0}, 24'h0, {8'h96, 16'h0});

        for (int t = 0; t < 50 && exp_rx.size() != 0; t++) @(negedge clk);
        check("rx_all_received", exp_rx.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/spi_slave.md
SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, frame length in bits.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, RX FIFO entries (power of two); used only with SPI_SLAVE_RX_FIFO_EN.
REQ-003 SHALL have port clk  input  1  system clock; all state in this domain.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port sclk  input  1  SPI clock from master, asynchronous to clk.
REQ-006 SHALL have port ss  input  1  slave select, active-low, asynchronous.
REQ-007 SHALL have port mosi  input  1  serial data from master.
REQ-008 SHALL have port miso  output  1  serial data to master.
REQ-009 SHALL have port misoEnable  output  1  high while selected; top level drives pad high-Z otherwise.
REQ-010 SHALL have port txData  input  DATA_WIDTH  next byte to send.
REQ-011 SHALL have port txValid  input  1  txData holds a byte.
REQ-012 SHALL have port txReady  output  1  one-cycle pulse: txData consumed this cycle.
REQ-013 SHALL have port rxData  output  DATA_WIDTH  received byte at buffer head.
REQ-014 SHALL have port rxValid  output  1  rxData valid.
REQ-015 SHALL have port rxReady  input  1  consumer pops rxData when rxValid&rxReady.
REQ-016 SHALL have port txUnderrun  output  1  one-cycle pulse: load with txValid low.
REQ-017 SHALL have port rxOverrun  output  1  one-cycle pulse: completed byte dropped.
REQ-018 SHALL have port busy  output  1  high in state SHIFT.

Function
REQ-019 SHALL implement SPI mode 0 (CPOL=0, CPHA=0), MSB first.
REQ-020 SHALL pass sclk, ss, mosi through 2-flop synchronizers and detect edges on the synchronized sclk/ss; supported sclk <= clk/8.
REQ-021 SHALL use FSM states IDLE and SHIFT; IDLE->SHIFT on synchronized ss falling edge; any state->IDLE when synchronized ss high.
REQ-022 SHALL, on IDLE->SHIFT, load tx shift register from txData and pulse txReady if txValid, else load all-ones and pulse txUnderrun; bit counter cleared.
REQ-023 SHALL sample synchronized mosi into rx shift register on each sclk rising edge in SHIFT and increment bit counter.
REQ-024 SHALL shift tx register left on each sclk falling edge in SHIFT, except the falling edge after bit DATA_WIDTH-1, which reloads per REQ-022 (back-to-back frames while ss low).
REQ-025 SHALL drive miso = tx shift register MSB; misoEnable = synchronized ss low; master SHALL allow >= 4 clk from ss fall to first sclk rise.
REQ-026 SHALL, in the cycle after the DATA_WIDTH-th rising edge, push the rx byte to the buffer; bit counter wraps to 0.
REQ-027 SHALL, if buffer full at push and no pop that cycle, drop the byte and pulse rxOverrun; simultaneous push and pop on full SHALL both occur, no overrun.
REQ-028 SHALL discard a partial byte when ss rises mid-frame: no push, no rxValid, counter cleared.
REQ-029 SHALL keep txReady, txUnderrun, rxOverrun low outside the single pulse cycles.

Reset
REQ-030 SHALL on reset: state IDLE, counters 0, tx shift all-ones, miso 1, misoEnable 0, txReady 0, rxData 0, rxValid 0, txUnderrun 0, rxOverrun 0, busy 0, buffer empty.
REQ-031 SHALL abort any frame on reset assertion; after release SHALL wait for a fresh ss falling edge.

Configuration
REQ-032 SHALL with SPI_SLAVE_RX_FIFO_EN defined buffer received bytes in a FIFO_DEPTH-entry FIFO, wrapping pointers, rxValid = not empty, first-word fall-through.
REQ-033 SHALL without SPI_SLAVE_RX_FIFO_EN use a single holding register; full when rxValid high.

Structure
REQ-034 SHALL place state enum (IDLE, SHIFT) and default DATA_WIDTH/FIFO_DEPTH constants in package spi_slave_pkg.
REQ-035 SHALL implement the FIFO as sub-module spi_slave_rx_fifo, instantiated only under SPI_SLAVE_RX_FIFO_EN.

Verification
REQ-036 SHALL cover: txData=8'hA5, txValid high, master sends 8'h3C -> MISO bits 10100101, rxData=8'h3C, rxValid, one txReady pulse.
REQ-037 SHALL cover: txValid low at ss fall -> miso shifts 8'hFF, one txUnderrun pulse.
REQ-038 SHALL cover: ss held low for 3 bytes 01,02,03, rxReady high, txData 10,11,12 -> rx 01,02,03 in order, tx 10,11,12, three txReady pulses.
REQ-039 SHALL cover: ss rises after 5 bits -> no rxValid; next full frame 8'h81 received correctly.
REQ-040 SHALL cover: rxReady low, send depth+1 bytes (1 without FIFO) -> last byte dropped, one rxOverrun pulse, earlier bytes intact.
REQ-041 SHALL cover: reset asserted after bit 3 -> all outputs at reset values within one clk, next frame 8'h5A correct.
